// File: rtl/cam_bob_pkg.sv
// Shared widths, read-FSM encoding and output line-number arithmetic for the bob line sequencer.
// Pure declarations: no latency, no flow control.
package cam_bob_pkg;
   localparam int ADDR_W_DEF = 10;
   localparam int LINE_IDX_W = 11;
   localparam int DROP_CNT_W = 8;
   localparam int K_W        = 10;

   typedef enum logic [1:0] {
      R_IDLE   = 2'd0,
      R_FIRST  = 2'd1,
      R_SECOND = 2'd2
   } rd_state_e;

   // Each input line k of field parity p becomes output lines 2k+p and 2k+p+1.
   function automatic logic [LINE_IDX_W-1:0] line_idx(input logic [K_W-1:0] k,
                                                      input logic p,
                                                      input logic rep);
      return LINE_IDX_W'({k, 1'b0}) + LINE_IDX_W'(p) + LINE_IDX_W'(rep);
   endfunction
endpackage

// File: rtl/cam_bob_read_sequencer.sv
// Emits each stored bank twice (first, then bob duplicate); rd_start one cycle after the trigger.
// Backpressure: waits on rd_done indefinitely; releases the bank combinationally on the final rd_done.
module cam_bob_read_sequencer
   import cam_bob_pkg::*;
(
   input  logic                    cam_pclk,
   input  logic                    cam_resetn,
   input  logic [1:0]              full_i,
   input  logic [1:0][K_W-1:0]     bank_k_i,
   input  logic [1:0]              bank_p_i,
   input  logic                    rd_done_i,
   output logic                    rd_start_o,
   output logic                    rd_bank_o,
   output logic                    rd_repeat_o,
   output logic [LINE_IDX_W-1:0]   rd_line_idx_o,
   output logic                    clr_vld_o,
   output logic                    clr_bank_o
);
   rd_state_e             state_q;
   logic                  rd_ptr_q;
   logic                  start_q;
   logic                  bank_q;
   logic                  rep_q;
   logic [LINE_IDX_W-1:0] idx_q;

   always_ff @(posedge cam_pclk or negedge cam_resetn) begin
      if (!cam_resetn) begin
         state_q  <= R_IDLE;
         rd_ptr_q <= 1'b0;
         start_q  <= 1'b0;
         bank_q   <= 1'b0;
         rep_q    <= 1'b0;
         idx_q    <= '0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            R_IDLE: begin
               if (full_i[rd_ptr_q]) begin
                  start_q <= 1'b1;
                  bank_q  <= rd_ptr_q;
                  rep_q   <= 1'b0;
                  idx_q   <= line_idx(bank_k_i[rd_ptr_q], bank_p_i[rd_ptr_q], 1'b0);
                  state_q <= R_FIRST;
               end
            end
            R_FIRST: begin
               if (rd_done_i) begin
                  start_q <= 1'b1;
                  rep_q   <= 1'b1;
                  idx_q   <= line_idx(bank_k_i[rd_ptr_q], bank_p_i[rd_ptr_q], 1'b1);
                  state_q <= R_SECOND;
               end
            end
            R_SECOND: begin
               if (rd_done_i) begin
                  rd_ptr_q <= ~rd_ptr_q;
                  state_q  <= R_IDLE;
               end
            end
            default: state_q <= R_IDLE;
         endcase
      end
   end

   // Full bit clears on the same edge the FSM returns to idle, so idle never sees a stale bank.
   assign clr_vld_o     = (state_q == R_SECOND) && rd_done_i;
   assign clr_bank_o    = rd_ptr_q;
   assign rd_start_o    = start_q;
   assign rd_bank_o     = bank_q;
   assign rd_repeat_o   = rep_q;
   assign rd_line_idx_o = idx_q;
endmodule

// File: rtl/cam_bob_line_sequencer.sv
// Ping-pong line capture for bob deinterlace; pixel writes lag cam_line_valid by one cycle.
// Backpressure: a line arriving while its target bank is still full is dropped and counted.
module cam_bob_line_sequencer
   import cam_bob_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                    cam_pclk,
   input  logic                    cam_resetn,
   input  logic                    cam_line_valid,
   input  logic                    cam_field_toggle,
   input  logic                    cam_field_odd,
   output logic                    buf_wr_en,
   output logic                    buf_wr_bank,
   output logic [ADDR_W-1:0]       buf_wr_addr,
   output logic                    rd_start,
   output logic                    rd_bank,
   output logic                    rd_repeat,
   output logic [LINE_IDX_W-1:0]   rd_line_idx,
   input  logic                    rd_done,
   output logic                    line_dropped,
   output logic [DROP_CNT_W-1:0]   drop_count
);
   logic                  lv_q, tg_q;
   logic [K_W-1:0]        k_q, cur_k_q;
   logic                  p_q, cur_p_q;
   logic                  wr_ptr_q;
   logic [1:0]            full_q, full_d;
   logic [1:0][K_W-1:0]   bank_k_q;
   logic [1:0]            bank_p_q;
   logic                  act_q;
   logic [ADDR_W:0]       pix_q;
   logic                  wr_en_q, wr_bank_q;
   logic [ADDR_W-1:0]     wr_addr_q;
   logic                  drop_q;
   logic [DROP_CNT_W-1:0] drop_cnt_q;

   logic                  line_rise, line_fall, tog_edge, accept, store;
   logic [K_W-1:0]        k_eff;
   logic                  p_eff;
   logic                  clr_vld, clr_bank;

   assign line_rise = cam_line_valid & ~lv_q;
   assign line_fall = ~cam_line_valid & lv_q;
   assign tog_edge  = cam_field_toggle ^ tg_q;
   // A boundary coinciding with a line start applies to that line.
   assign k_eff     = tog_edge ? '0 : k_q;
   assign p_eff     = tog_edge ? cam_field_odd : p_q;
   assign accept    = line_rise & ~full_q[wr_ptr_q];
   assign store     = line_fall & act_q;

   always_comb begin
      full_d = full_q;
      if (clr_vld) full_d[clr_bank] = 1'b0;
      if (store)   full_d[wr_ptr_q] = 1'b1;
   end

   always_ff @(posedge cam_pclk or negedge cam_resetn) begin
      if (!cam_resetn) begin
         lv_q       <= 1'b1;
         tg_q       <= 1'b0;
         k_q        <= '0;
         p_q        <= 1'b0;
         cur_k_q    <= '0;
         cur_p_q    <= 1'b0;
         wr_ptr_q   <= 1'b0;
         full_q     <= 2'b00;
         bank_k_q   <= '0;
         bank_p_q   <= 2'b00;
         act_q      <= 1'b0;
         pix_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_bank_q  <= 1'b0;
         wr_addr_q  <= '0;
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         lv_q   <= cam_line_valid;
         tg_q   <= cam_field_toggle;
         full_q <= full_d;
         drop_q <= 1'b0;

         if (tog_edge) begin
            k_q <= '0;
            p_q <= cam_field_odd;
         end
         if (line_rise) k_q <= k_eff + K_W'(1);

         if (accept) begin
            act_q     <= 1'b1;
            cur_k_q   <= k_eff;
            cur_p_q   <= p_eff;
            wr_bank_q <= wr_ptr_q;
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            pix_q     <= (ADDR_W+1)'(1);
         end else if (act_q && cam_line_valid) begin
            // Pixels past the end of the bank are discarded; the address parks at the last slot.
            if (!pix_q[ADDR_W]) begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= pix_q[ADDR_W-1:0];
               pix_q     <= pix_q + (ADDR_W+1)'(1);
            end else begin
               wr_en_q <= 1'b0;
            end
         end else begin
            wr_en_q <= 1'b0;
         end

         if (line_rise && full_q[wr_ptr_q]) begin
            drop_q <= 1'b1;
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
         end

         if (store) begin
            act_q              <= 1'b0;
            bank_k_q[wr_ptr_q] <= cur_k_q;
            bank_p_q[wr_ptr_q] <= cur_p_q;
            wr_ptr_q           <= ~wr_ptr_q;
         end
      end
   end

   cam_bob_read_sequencer u_rd_seq (
      .cam_pclk      (cam_pclk),
      .cam_resetn    (cam_resetn),
      .full_i        (full_q),
      .bank_k_i      (bank_k_q),
      .bank_p_i      (bank_p_q),
      .rd_done_i     (rd_done),
      .rd_start_o    (rd_start),
      .rd_bank_o     (rd_bank),
      .rd_repeat_o   (rd_repeat),
      .rd_line_idx_o (rd_line_idx),
      .clr_vld_o     (clr_vld),
      .clr_bank_o    (clr_bank)
   );

   assign buf_wr_en    = wr_en_q;
   assign buf_wr_bank  = wr_bank_q;
   assign buf_wr_addr  = wr_addr_q;
   assign line_dropped = drop_q;
   assign drop_count   = drop_cnt_q;
endmodule

// File: tb/tb_cam_bob_line_sequencer.sv
// Bench for cam_bob_line_sequencer: line-level reference model of bank occupancy, field numbering and drops.
module tb_cam_bob_line_sequencer;
   localparam int ADDR_W = 10;
   localparam int MAXPIX = 1 << ADDR_W;

   logic cam_pclk = 1'b0;
   logic cam_resetn = 1'b1;
   logic cam_line_valid = 1'b0;
   logic cam_field_toggle = 1'b0;
   logic cam_field_odd = 1'b0;
   logic rd_done = 1'b0;
   logic buf_wr_en, buf_wr_bank, rd_start, rd_bank, rd_repeat, line_dropped;
   logic [ADDR_W-1:0] buf_wr_addr;
   logic [10:0] rd_line_idx;
   logic [7:0] drop_count;

   cam_bob_line_sequencer #(.ADDR_W(ADDR_W)) dut (
      .cam_pclk(cam_pclk), .cam_resetn(cam_resetn), .cam_line_valid(cam_line_valid),
      .cam_field_toggle(cam_field_toggle), .cam_field_odd(cam_field_odd),
      .buf_wr_en(buf_wr_en), .buf_wr_bank(buf_wr_bank), .buf_wr_addr(buf_wr_addr),
      .rd_start(rd_start), .rd_bank(rd_bank), .rd_repeat(rd_repeat), .rd_line_idx(rd_line_idx),
      .rd_done(rd_done), .line_dropped(line_dropped), .drop_count(drop_count)
   );

   always #5 cam_pclk = ~cam_pclk;

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   // Reference model state
   int k_m = 0, p_m = 0, acc_total = 0, drop_m = 0, exp_writes = 0;
   int rel_q[$];
   logic [12:0] exp_q[$];
   // Observations
   logic [12:0] got_q[$];
   int wr_total = 0, wr_err = 0, drops_seen = 0, exp_addr = 0;
   logic exp_bank = 1'b0;
   // Reader emulation
   bit rd_auto = 1'b1, rd_busy = 1'b0, rd_rep;
   int dmin = 1, dmax = 1, rd_d;

   initial forever begin
      @(posedge cam_pclk);
      cyc++;
   end

   initial forever begin
      @(negedge cam_pclk);
      if (buf_wr_en) begin
         if (buf_wr_addr !== ADDR_W'(exp_addr) || buf_wr_bank !== exp_bank) wr_err++;
         exp_addr++;
         wr_total++;
      end
      if (line_dropped) drops_seen++;
      if (rd_start) got_q.push_back({rd_bank, rd_repeat, rd_line_idx});
   end

   initial forever begin
      @(negedge cam_pclk);
      if (rd_start && rd_auto && cam_resetn) begin
         rd_rep = rd_repeat;
         rd_busy = 1'b1;
         rd_d = $urandom_range(dmax, dmin);
         repeat (rd_d) @(posedge cam_pclk);
         #1 rd_done = 1'b1;
         if (rd_rep) rel_q.push_back(cyc);
         @(posedge cam_pclk);
         #1 rd_done = 1'b0;
         rd_busy = 1'b0;
      end
   end

   function automatic int released_before(input int c);
      int r = 0;
      foreach (rel_q[i]) if (rel_q[i] < c) r++;
      return r;
   endfunction

   function automatic logic [34:0] all_out();
      return {buf_wr_en, buf_wr_bank, buf_wr_addr, rd_start, rd_bank, rd_repeat,
              rd_line_idx, line_dropped, drop_count};
   endfunction

   task automatic clear_model();
      k_m = 0; p_m = 0; acc_total = 0; drop_m = 0; exp_writes = 0;
      rel_q.delete(); exp_q.delete(); got_q.delete();
      wr_total = 0; wr_err = 0; drops_seen = 0; exp_addr = 0;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 5000 && rd_busy; i++) @(posedge cam_pclk);
      @(posedge cam_pclk);
      #3 cam_resetn = 1'b0;
      rd_done = 1'b0; cam_line_valid = 1'b0; cam_field_toggle = 1'b0; cam_field_odd = 1'b0;
      clear_model();
      repeat (2) @(posedge cam_pclk);
      #1 cam_resetn = 1'b1;
      @(posedge cam_pclk);
      #1;
   endtask

   // Called at posedge+1; models acceptance from bank occupancy as seen at the sampling edge.
   task automatic drive_line(input int len, input bit tog_rise, input bit odd,
                             input int tog_mid_at, input int gap);
      logic [10:0] ix;
      logic bk;
      if (tog_rise) begin
         cam_field_toggle = ~cam_field_toggle; cam_field_odd = odd; k_m = 0; p_m = odd;
      end
      ix = 11'(2 * k_m + p_m);
      k_m = (k_m + 1) % 1024;
      if (acc_total - released_before(cyc) < 2) begin
         bk = acc_total[0];
         exp_q.push_back({bk, 1'b0, ix});
         exp_q.push_back({bk, 1'b1, ix + 11'd1});
         exp_bank = bk;
         exp_addr = 0;
         exp_writes += (len > MAXPIX) ? MAXPIX : len;
         acc_total++;
      end else begin
         drop_m++;
      end
      cam_line_valid = 1'b1;
      for (int i = 1; i < len; i++) begin
         @(posedge cam_pclk);
         #1;
         if (i == tog_mid_at) begin
            cam_field_toggle = ~cam_field_toggle; cam_field_odd = odd; k_m = 0; p_m = odd;
         end
      end
      @(posedge cam_pclk);
      #1 cam_line_valid = 1'b0;
      repeat (gap + 1) @(posedge cam_pclk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_chk++;
      if (all_out() !== 35'd0) $display("FAIL reset_outputs: got %h want 0", all_out());
      else n_pass++;
      repeat (3) @(posedge cam_pclk);
      #1 cam_resetn = 1'b1;
      repeat (3) @(posedge cam_pclk);
      #1;
      n_chk++;
      if (all_out() !== 35'd0) $display("FAIL idle_after_reset: got %h want 0", all_out());
      else n_pass++;
   endtask

   task automatic test_even_field();
      rd_auto = 1'b1; dmin = 50; dmax = 50;
      for (int n = 0; n < 3; n++) drive_line(720, n == 0, 1'b0, 0, 5);
      for (int i = 0; i < 20000 && (got_q.size() < exp_q.size() || rd_busy); i++) @(posedge cam_pclk);
      #1;
      n_chk++;
      if (got_q.size() != 6) $display("FAIL even_count: got %0d want 6", got_q.size());
      else n_pass++;
      for (int i = 0; i < got_q.size() && i < 6; i++) begin
         n_chk++;
         if (got_q[i] !== exp_q[i] || got_q[i][10:0] !== 11'(i))
            $display("FAIL even_rd[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      n_chk++;
      if (wr_total != 2160 || wr_err != 0 || drops_seen != 0)
         $display("FAIL even_writes: got %0d err %0d drops %0d want 2160/0/0", wr_total, wr_err, drops_seen);
      else n_pass++;
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_odd_field();
      dmin = 3; dmax = 12;
      drive_line(30, 1'b1, 1'b1, 0, 4);
      for (int i = 0; i < 5000 && (got_q.size() < exp_q.size() || rd_busy); i++) @(posedge cam_pclk);
      #1;
      n_chk++;
      if (got_q.size() != 2) $display("FAIL odd_count: got %0d want 2", got_q.size());
      else n_pass++;
      if (got_q.size() == 2) begin
         n_chk++;
         if (got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1] || got_q[0][10:0] !== 11'd1 ||
             got_q[1][10:0] !== 11'd2 || got_q[0][12] !== got_q[1][12])
            $display("FAIL odd_pair: got %h %h want %h %h", got_q[0], got_q[1], exp_q[0], exp_q[1]);
         else n_pass++;
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_same_cycle_toggle();
      dmin = 5; dmax = 15;
      drive_line(12, 1'b0, 1'b0, 0, 3);
      drive_line(12, 1'b0, 1'b0, 0, 3);
      drive_line(12, 1'b1, 1'b0, 0, 3);
      for (int i = 0; i < 5000 && (got_q.size() < exp_q.size() || rd_busy); i++) @(posedge cam_pclk);
      #1;
      n_chk++;
      if (got_q.size() != exp_q.size()) $display("FAIL tog_count: got %0d want %0d", got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (got_q[i] !== exp_q[i]) $display("FAIL tog_rd[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      if (got_q.size() == 6) begin
         n_chk++;
         if (got_q[4][10:0] !== 11'd0 || got_q[5][10:0] !== 11'd1)
            $display("FAIL tog_k0: got %0d %0d want 0 1", got_q[4][10:0], got_q[5][10:0]);
         else n_pass++;
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_long_line();
      do_reset();
      rd_auto = 1'b1; dmin = 20; dmax = 20;
      drive_line(1100, 1'b0, 1'b0, 0, 2);
      n_chk++;
      if (wr_total != 1024 || wr_err != 0 || buf_wr_addr !== 10'd1023)
         $display("FAIL long_writes: got %0d err %0d addr %0d want 1024/0/1023", wr_total, wr_err, buf_wr_addr);
      else n_pass++;
      for (int i = 0; i < 5000 && (got_q.size() < exp_q.size() || rd_busy); i++) @(posedge cam_pclk);
      #1;
      n_chk++;
      if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1])
         $display("FAIL long_emit: got %0d entries want 2 (%h %h)", got_q.size(), exp_q[0], exp_q[1]);
      else n_pass++;
   endtask

   task automatic test_drop();
      do_reset();
      rd_auto = 1'b0;
      for (int n = 0; n < 3; n++) drive_line(20, 1'b0, 1'b0, 0, 3);
      n_chk++;
      if (drops_seen != 1 || drop_count !== 8'd1 || wr_total != 40)
         $display("FAIL drop_one: got pulses %0d count %0d writes %0d want 1/1/40", drops_seen, drop_count, wr_total);
      else n_pass++;
      for (int n = 0; n < 300; n++) drive_line(2, 1'b0, 1'b0, 0, 1);
      n_chk++;
      if (drop_count !== 8'd255 || drops_seen != drop_m || wr_total != 40)
         $display("FAIL drop_sat: got count %0d pulses %0d writes %0d want 255/%0d/40", drop_count, drops_seen, wr_total, drop_m);
      else n_pass++;
      n_chk++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0])
         $display("FAIL drop_reads: got %0d entries want 1 (%h)", got_q.size(), exp_q[0]);
      else n_pass++;
   endtask

   task automatic test_reset_midline();
      cam_line_valid = 1'b1;
      repeat (5) @(posedge cam_pclk);
      #3 cam_resetn = 1'b0;
      cam_field_toggle = 1'b0; cam_field_odd = 1'b0;
      clear_model();
      #1;
      n_chk++;
      if (all_out() !== 35'd0) $display("FAIL midline_reset_outputs: got %h want 0", all_out());
      else n_pass++;
      rd_auto = 1'b1; dmin = 4; dmax = 10;
      repeat (2) @(posedge cam_pclk);
      #1 cam_resetn = 1'b1;
      repeat (10) @(posedge cam_pclk);
      #1;
      n_chk++;
      if (wr_total != 0 || all_out() !== 35'd0)
         $display("FAIL midline_ignored: got writes %0d outputs %h want 0/0", wr_total, all_out());
      else n_pass++;
      cam_line_valid = 1'b0;
      repeat (2) @(posedge cam_pclk);
      #1;
      drive_line(8, 1'b0, 1'b0, 0, 2);
      for (int i = 0; i < 5000 && (got_q.size() < exp_q.size() || rd_busy); i++) @(posedge cam_pclk);
      #1;
      n_chk++;
      if (wr_total != 8 || wr_err != 0 || got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1])
         $display("FAIL midline_next: got writes %0d err %0d reads %0d want 8/0/2", wr_total, wr_err, got_q.size());
      else n_pass++;
   endtask

   task automatic test_random();
      int len, tm, gap;
      bit tr, od;
      do_reset();
      rd_auto = 1'b1; dmin = 1; dmax = 40;
      for (int n = 0; n < 60; n++) begin
         len = $urandom_range(40, 1);
         tr  = ($urandom_range(4, 0) == 0);
         od  = $urandom_range(1, 0);
         tm  = ($urandom_range(4, 0) == 0) ? int'($urandom_range(len, 1)) : 0;
         gap = $urandom_range(8, 1);
         drive_line(len, tr, od, tm, gap);
      end
      for (int i = 0; i < 20000 && (got_q.size() < exp_q.size() || rd_busy); i++) @(posedge cam_pclk);
      #1;
      n_chk++;
      if (got_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (got_q[i] !== exp_q[i]) $display("FAIL rand_rd[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      n_chk++;
      if (wr_total != exp_writes || wr_err != 0)
         $display("FAIL rand_writes: got %0d err %0d want %0d/0", wr_total, wr_err, exp_writes);
      else n_pass++;
      n_chk++;
      if (drops_seen != drop_m || drop_count !== 8'((drop_m > 255) ? 255 : drop_m))
         $display("FAIL rand_drops: got pulses %0d count %0d want %0d", drops_seen, drop_count, drop_m);
      else n_pass++;
   endtask

   initial begin
      #1 cam_resetn = 1'b0;
      test_reset();
      test_even_field();
      test_odd_field();
      test_same_cycle_toggle();
      test_long_line();
      test_drop();
      test_reset_midline();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/cam_bob_line_sequencer.md
CAM_BOB_LINE_SEQUENCER -- requirements
Module: cam_bob_line_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, line-buffer pixel address width (max 2^ADDR_W pixels per line).
REQ-002 SHALL have port cam_pclk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port cam_resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cam_line_valid  input  1  high during active pixels of a camera line.
REQ-005 SHALL have port cam_field_toggle  input  1  level toggles at each field boundary.
REQ-006 SHALL have port cam_field_odd  input  1  parity of the field that starts at the toggle.
REQ-007 SHALL have port buf_wr_en  output  1  line-buffer write strobe.
REQ-008 SHALL have port buf_wr_bank  output  1  ping-pong bank being written.
REQ-009 SHALL have port buf_wr_addr  output  ADDR_W  pixel address within bank.
REQ-010 SHALL have port rd_start  output  1  one-cycle pulse telling the reader to emit a stored line.
REQ-011 SHALL have port rd_bank  output  1  bank to read; valid with rd_start.
REQ-012 SHALL have port rd_repeat  output  1  0 = first emission, 1 = bob duplicate; valid with rd_start.
REQ-013 SHALL have port rd_line_idx  output  11  output-frame line number; valid with rd_start.
REQ-014 SHALL have port rd_done  input  1  one-cycle pulse from reader when emission finishes.
REQ-015 SHALL have port line_dropped  output  1  one-cycle pulse when an input line is discarded.
REQ-016 SHALL have port drop_count  output  8  saturating count of dropped lines.

Function
REQ-017 SHALL register cam_line_valid and cam_field_toggle once for edge detection; all outputs SHALL be registered.
REQ-018 SHALL treat a field toggle edge as field boundary: input line counter k <= 0, latch cam_field_odd as p; banks already full are not flushed.
REQ-019 SHALL increment k at every line rising edge (dropped lines included), 10-bit wrap; toggle edge and line rising edge in the same cycle: boundary first, line gets k=0.
REQ-020 SHALL, at line rising edge, select bank wr_ptr; if full[wr_ptr]=1 the line is dropped: no writes, line_dropped pulse next cycle, drop_count +1 saturating at 255.
REQ-021 SHALL, for an accepted line, assert buf_wr_en one cycle after each cycle of cam_line_valid, buf_wr_addr starting at 0 and incrementing per pixel.
REQ-022 SHALL deassert buf_wr_en for pixels beyond address 2^ADDR_W-1 (address holds at max; excess pixels discarded, line still stored).
REQ-023 SHALL, at falling edge of an accepted line, set full[wr_ptr], store k for that bank, toggle wr_ptr.
REQ-024 SHALL run read FSM R_IDLE, R_FIRST, R_SECOND: R_IDLE with full[rd_ptr]=1 -> rd_start, rd_repeat=0 -> R_FIRST; R_FIRST on rd_done -> rd_start, rd_repeat=1 -> R_SECOND; R_SECOND on rd_done -> clear full[rd_ptr], toggle rd_ptr -> R_IDLE.
REQ-025 SHALL drive rd_line_idx = 2*k_stored + p + rd_repeat (11-bit, wraps), with p sampled at line capture time.
REQ-026 SHALL ignore rd_done in R_IDLE; a new rd_start SHALL come no earlier than the cycle after the full bit clears.
REQ-027 SHALL allow set of one bank's full bit and clear of the other in the same cycle; both take effect.
REQ-028 SHALL leave a line in progress across a field toggle written with its original k and p.

Reset
REQ-029 SHALL on cam_resetn low force immediately: all outputs 0, full=00, wr_ptr=rd_ptr=0, FSM R_IDLE, k=0, p=0, drop_count=0.
REQ-030 SHALL reset the registered line_valid to 1 so a line active at reset release is ignored; registered toggle resets to 0.

Structure
REQ-031 SHALL place ADDR_W default, line-index width 11, drop-count width 8 and read-FSM state encoding in package cam_bob_pkg.
REQ-032 SHALL implement the read FSM as sub-module cam_bob_read_sequencer.

Verification
REQ-033 Field p=0, three 720-pixel lines, rd_done 50 cycles after each rd_start -> rd_line_idx 0,1,2,3,4,5; 720 writes per line, addr 0..719.
REQ-034 Field p=1, one line -> rd_start pair with rd_line_idx 1 then 2, rd_bank identical.
REQ-035 rd_done withheld, three lines -> lines 1-2 stored, line 3 dropped: line_dropped pulse, drop_count=1, no writes; 300 drops -> drop_count=255.
REQ-036 1100-pixel line, ADDR_W=10 -> 1024 writes, addr holds 1023, line stored and emitted twice.
REQ-037 Toggle and line rising edge same cycle -> that line k=0; reset asserted mid-line with line_valid high through release -> no writes until next rising edge, all outputs 0.
